// File: rtl/cb_zigzag_serializer.sv
// Ping-pong buffered Cb block serializer: 64 coefficients per block in JPEG zigzag order, DC as DPCM diff.
// Latency: first coefficient valid one cycle after capture; stalls hold the word until coef_ready; in_ready drops with both banks full.
module cb_zigzag_serializer #(
    parameter int DW = 11
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic [7:0][7:0][DW-1:0] Q,
    output logic                    in_ready,
    input  logic                    dc_clear,
    output logic [DW:0]             coef_data,
    output logic [5:0]              coef_idx,
    output logic                    coef_last,
    output logic                    coef_valid,
    input  logic                    coef_ready,
    output logic                    overflow
);

    typedef enum logic {IDLE, DRAIN} state_t;

    localparam logic [5:0] ZZ [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    function automatic logic [DW:0] sext(input logic [DW-1:0] v);
        return {v[DW-1], v};
    endfunction

    // Packed Q flattens to raster order r*8+c, so each bank stores it verbatim.
    logic [63:0][DW-1:0] bank0, bank1;
    logic [63:0][DW-1:0] cur_bank, oth_bank;
    logic [1:0]          full, full_nxt;
    logic                wr_sel, rd_sel;
    state_t              state;
    logic [5:0]          k, k_inc;
    logic [DW:0]         pred, pred_eff;
    logic                capture, accept, release_blk;

    assign in_ready    = !(full[0] && full[1]);
    assign capture     = in_valid && in_ready;
    assign accept      = coef_valid && coef_ready;
    assign release_blk = (state == DRAIN) && accept && (k == 6'd63);
    assign k_inc       = k + 6'd1;
    assign coef_idx    = k;
    // A DC word loaded on a dc_clear edge already belongs to the new interval.
    assign pred_eff    = dc_clear ? '0 : pred;

    always_comb begin
        cur_bank = rd_sel ? bank1 : bank0;
        oth_bank = rd_sel ? bank0 : bank1;
        full_nxt = full;
        if (capture)
            full_nxt[wr_sel] = 1'b1;
        if (release_blk)
            full_nxt[rd_sel] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (capture && !wr_sel)
            bank0 <= Q;
        if (capture && wr_sel)
            bank1 <= Q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            k          <= '0;
            coef_valid <= 1'b0;
            coef_data  <= '0;
            coef_last  <= 1'b0;
            overflow   <= 1'b0;
            full       <= '0;
            wr_sel     <= 1'b0;
            rd_sel     <= 1'b0;
            pred       <= '0;
        end else begin
            full <= full_nxt;
            if (capture)
                wr_sel <= !wr_sel;
            if (in_valid && !in_ready)
                overflow <= 1'b1;

            if (dc_clear)
                pred <= '0;
            else if (state == DRAIN && accept && k == 6'd0)
                pred <= sext(cur_bank[0]);

            case (state)
                IDLE: begin
                    if (full[rd_sel]) begin
                        state      <= DRAIN;
                        k          <= '0;
                        coef_valid <= 1'b1;
                        coef_last  <= 1'b0;
                        coef_data  <= sext(cur_bank[0]) - pred_eff;
                    end
                end
                DRAIN: begin
                    if (accept) begin
                        if (k == 6'd63) begin
                            rd_sel <= !rd_sel;
                            if (full[!rd_sel]) begin
                                k         <= '0;
                                coef_last <= 1'b0;
                                coef_data <= sext(oth_bank[0]) - pred_eff;
                            end else begin
                                state      <= IDLE;
                                coef_valid <= 1'b0;
                                coef_last  <= 1'b0;
                            end
                        end else begin
                            k         <= k_inc;
                            coef_last <= (k == 6'd62);
                            coef_data <= sext(cur_bank[ZZ[k_inc]]);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cb_zigzag_serializer.sv
// Bench for cb_zigzag_serializer: table-driven DPCM cases, hand sequences, randomized blocks vs a queue model.
module tb_cb_zigzag_serializer;

    localparam int DW = 11;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    in_valid;
    logic [7:0][7:0][DW-1:0] q;
    logic                    in_ready;
    logic                    dc_clear;
    logic [DW:0]             coef_data;
    logic [5:0]              coef_idx;
    logic                    coef_last;
    logic                    coef_valid;
    logic                    coef_ready;
    logic                    overflow;

    cb_zigzag_serializer #(.DW(DW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .Q(q), .in_ready(in_ready),
        .dc_clear(dc_clear), .coef_data(coef_data), .coef_idx(coef_idx),
        .coef_last(coef_last), .coef_valid(coef_valid), .coef_ready(coef_ready),
        .overflow(overflow)
    );

    always #5 clk = !clk;

    typedef struct {
        int d;
        int idx;
        bit last;
    } beat_t;

    typedef struct {
        int dc;
        bit clr;
        int exp_dc;
    } dpcm_vec_t;

    int    n_chk = 0;
    int    n_pass = 0;
    int    zz [64];
    beat_t exp_q [$];
    int    pending = 0;
    int    mpred = 0;
    bit    exp_ovf = 0;
    bit    prev_stall = 0;
    int    prev_d, prev_idx, prev_last;
    int    run = 0;
    int    max_run = 0;
    int    beats = 0;
    bit    rnd_ready = 0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Reference model: blocks enter a queue of expected beats at capture time.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            pending    = 0;
            mpred      = 0;
            exp_ovf    = 0;
            prev_stall = 0;
            run        = 0;
        end else begin
            bit rdy;
            rdy = (pending < 2);
            check("in_ready", int'(in_ready), int'(rdy));
            check("overflow", int'(overflow), int'(exp_ovf));
            if (prev_stall) begin
                check("stall_valid", int'(coef_valid), 1);
                check("stall_data", int'($signed(coef_data)), prev_d);
                check("stall_idx", int'(coef_idx), prev_idx);
                check("stall_last", int'(coef_last), prev_last);
            end
            if (coef_valid) run++; else run = 0;
            if (run > max_run) max_run = run;
            if (coef_valid && coef_ready) begin
                check("beat_expected", int'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    beat_t b;
                    b = exp_q.pop_front();
                    check("data", int'($signed(coef_data)), b.d);
                    check("idx", int'(coef_idx), b.idx);
                    check("last", int'(coef_last), int'(b.last));
                    beats++;
                    if (b.last) pending--;
                end
            end
            prev_stall = coef_valid && !coef_ready;
            prev_d     = int'($signed(coef_data));
            prev_idx   = int'(coef_idx);
            prev_last  = int'(coef_last);
            if (dc_clear) mpred = 0;
            if (in_valid) begin
                if (rdy) begin
                    for (int kk = 0; kk < 64; kk++) begin
                        beat_t b;
                        int v;
                        v = int'($signed(q[zz[kk] / 8][zz[kk] % 8]));
                        b.d    = (kk == 0) ? v - mpred : v;
                        b.idx  = kk;
                        b.last = (kk == 63);
                        exp_q.push_back(b);
                    end
                    mpred = int'($signed(q[0][0]));
                    pending++;
                end else begin
                    exp_ovf = 1;
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_ready) coef_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_raster();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                q[r][c] = DW'(r * 8 + c);
    endtask

    task automatic set_rand();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                q[r][c] = DW'($urandom);
    endtask

    task automatic send_block();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 3000; i++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        check(name, exp_q.size(), 0);
        tick();
    endtask

    task automatic get_dc(input string name, output int val);
        bit found;
        found = 0;
        val   = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (coef_valid && coef_idx == 6'd0) begin
                found = 1;
                val   = int'($signed(coef_data));
                break;
            end
        end
        check(name, int'(found), 1);
    endtask

    initial begin
        dpcm_vec_t vecs [4];
        int        kz, dcv, b0;

        kz = 0;
        for (int s = 0; s < 15; s++) begin
            if (s % 2 == 0) begin
                for (int r = (s < 8 ? s : 7); r >= 0 && s - r < 8; r--) begin
                    zz[kz] = r * 8 + (s - r);
                    kz++;
                end
            end else begin
                for (int r = (s < 8 ? 0 : s - 7); r < 8 && r <= s; r++) begin
                    zz[kz] = r * 8 + (s - r);
                    kz++;
                end
            end
        end

        vecs[0] = '{dc: 100, clr: 1'b1, exp_dc: 100};
        vecs[1] = '{dc: -50, clr: 1'b0, exp_dc: -150};
        vecs[2] = '{dc: -50, clr: 1'b0, exp_dc: 0};
        vecs[3] = '{dc: 7,   clr: 1'b1, exp_dc: 7};

        rst_n = 1'b0; in_valid = 1'b0; dc_clear = 1'b0; coef_ready = 1'b1; q = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_valid", int'(coef_valid), 0);
        check("rst_data", int'(coef_data), 0);
        check("rst_idx", int'(coef_idx), 0);
        check("rst_last", int'(coef_last), 0);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_overflow", int'(overflow), 0);
        tick();

        // Raster-valued block, always ready: zigzag order and first-beat latency.
        set_raster();
        send_block();
        @(negedge clk);
        check("lat_pre_valid", int'(coef_valid), 0);
        tick();
        check("lat_first_valid", int'(coef_valid), 1);
        check("lat_first_idx", int'(coef_idx), 0);
        tick();
        check("t2_k1_data", int'(coef_data), 1);
        tick();
        check("t2_k2_data", int'(coef_data), 8);
        wait_drain("t2_drain");

        // Same block under random backpressure.
        set_raster();
        rnd_ready = 1;
        send_block();
        wait_drain("t4_drain");
        rnd_ready = 0;
        coef_ready = 1'b1;
        tick();

        // DPCM table.
        foreach (vecs[i]) begin
            if (vecs[i].clr) begin
                dc_clear = 1'b1;
                tick();
                dc_clear = 1'b0;
            end
            set_rand();
            q[0][0] = DW'(vecs[i].dc);
            send_block();
            get_dc($sformatf("t3_found_%0d", i), dcv);
            check($sformatf("t3_dc_%0d", i), dcv, vecs[i].exp_dc);
            wait_drain($sformatf("t3_drain_%0d", i));
        end

        // Ping-pong: blocks at cycles 0 and 5 stream with no bubble.
        max_run = 0;
        set_rand();
        send_block();
        repeat (4) tick();
        set_rand();
        send_block();
        wait_drain("t5_drain");
        check("t5_run", max_run, 128);

        // Randomized blocks and gaps under random backpressure.
        rnd_ready = 1;
        for (int n = 0; n < 6; n++) begin
            set_rand();
            for (int i = 0; i < 300; i++) begin
                if (in_ready) break;
                tick();
            end
            send_block();
            repeat ($urandom_range(0, 40)) tick();
        end
        wait_drain("rand_drain");
        rnd_ready = 0;
        coef_ready = 1'b1;
        tick();

        // Reset mid-drain discards the block and the predictor.
        set_rand();
        send_block();
        repeat (20) tick();
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("t1_valid", int'(coef_valid), 0);
        check("t1_in_ready", int'(in_ready), 1);
        check("t1_overflow", int'(overflow), 0);
        tick();
        set_rand();
        q[0][0] = DW'(-5);
        send_block();
        get_dc("t1_found", dcv);
        check("t1_dc", dcv, -5);
        wait_drain("t1_drain");

        // Overflow: three blocks with the sink stalled.
        coef_ready = 1'b0;
        set_rand();
        send_block();
        set_rand();
        send_block();
        @(negedge clk);
        check("t6_in_ready", int'(in_ready), 0);
        tick();
        set_rand();
        send_block();
        @(negedge clk);
        check("t6_overflow", int'(overflow), 1);
        tick();
        b0 = beats;
        coef_ready = 1'b1;
        wait_drain("t6_drain");
        check("t6_beats", beats - b0, 128);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
